// File: rtl/mib_pkg.sv
// Shared definitions for the MIB responder: bus widths, address-phase field
// positions, FSM state encoding and the default timeout read pattern.
package mib_pkg;

    localparam int MIB_AD_BITS   = 16;
    localparam int CMD_ADDR_BITS = 24;
    localparam int CMD_DATA_BITS = 32;

    // Address phase 1 carries addr[23:16] in its low byte; the high byte is unused.
    localparam int A1_ADDR_MSB   = 7;
    localparam int A1_ADDR_LSB   = 0;
    localparam int ADDR_HI_MSB   = 23;
    localparam int ADDR_HI_LSB   = 16;
    localparam int ADDR_LO_MSB   = 15;
    localparam int ADDR_LO_LSB   = 0;
    localparam int ADDR_MSN_MSB  = 23;
    localparam int ADDR_MSN_LSB  = 20;

    localparam logic [CMD_DATA_BITS-1:0] TIMEOUT_RDATA = 32'hBAD0_BAD0;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR2    = 4'd1,
        ST_WDATA_HI = 4'd2,
        ST_WDATA_LO = 4'd3,
        ST_CMD_REQ  = 4'd4,
        ST_CMD_WAIT = 4'd5,
        ST_WR_ACK   = 4'd6,
        ST_RD_HI    = 4'd7,
        ST_RD_LO    = 4'd8,
        ST_SKIP     = 4'd9
    } mib_slv_state_t;

    function automatic logic [MIB_AD_BITS-1:0] data_half(
        input logic [CMD_DATA_BITS-1:0] data,
        input logic                     hi
    );
        logic [MIB_AD_BITS-1:0] half;
        if (hi) begin
            half = data[31:16];
        end else begin
            half = data[15:0];
        end
        return half;
    endfunction

endpackage

// File: rtl/mib_slave_if.sv
// FPGA-local command bus: one-clock sel strobe, completion signalled by ack.
interface intf_cmd #(
    parameter int ADDR_BITS = 24,
    parameter int DATA_BITS = 32
);
    logic                 sel;
    logic                 rd_wr_n;
    logic [ADDR_BITS-1:0] byte_addr;
    logic [DATA_BITS-1:0] wdata;
    logic                 ack;
    logic [DATA_BITS-1:0] rdata;

    modport master (
        output sel, rd_wr_n, byte_addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  sel, rd_wr_n, byte_addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mib_slave.sv
// MIB responder: collects two address and two data phases from the MIB master,
// replays them as one 32-bit local access and returns ack or read data.
module mib_slave
    import mib_pkg::*;
#(
    parameter logic [3:0]               P_MIB_MSN              = 4'h0,
    parameter int                       P_CMD_ACK_TIMEOUT_CLKS = 16,
    parameter logic [CMD_DATA_BITS-1:0] P_TIMEOUT_RDATA        = TIMEOUT_RDATA
) (
    input  logic                   i_sysclk,
    input  logic                   i_srst,
    input  logic                   i_mib_start,
    input  logic                   i_mib_rd_wr_n,
    input  logic [MIB_AD_BITS-1:0] i_mib_ad,
    output logic [MIB_AD_BITS-1:0] o_mib_ad,
    output logic                   o_mib_ad_oe,
    output logic                   o_mib_slave_ack,
    intf_cmd.master                cmd_master,
    output logic                   o_cmd_timeout
);

    localparam int                CNT_W    = $clog2(P_CMD_ACK_TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(P_CMD_ACK_TIMEOUT_CLKS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    mib_slv_state_t             state_r;
    logic [CNT_W-1:0]           cnt_r;
    logic                       skip_r;
    logic [CMD_DATA_BITS-1:0]   rdata_r;
    logic                       sel_r;
    logic                       rd_wr_n_r;
    logic [CMD_ADDR_BITS-1:0]   byte_addr_r;
    logic [CMD_DATA_BITS-1:0]   wdata_r;
    logic [MIB_AD_BITS-1:0]     ad_r;
    logic                       oe_r;
    logic                       slave_ack_r;
    logic                       timeout_r;

    logic                       timeout_hit_s;
    logic                       cmd_done_s;
    logic [CMD_DATA_BITS-1:0]   resp_data_s;

    assign cmd_master.sel       = sel_r;
    assign cmd_master.rd_wr_n   = rd_wr_n_r;
    assign cmd_master.byte_addr = byte_addr_r;
    assign cmd_master.wdata     = wdata_r;
    assign o_mib_ad             = ad_r;
    assign o_mib_ad_oe          = oe_r;
    assign o_mib_slave_ack      = slave_ack_r;
    assign o_cmd_timeout        = timeout_r;

    // Completion of the local access; a real ack beats the terminal count.
    always_comb begin
        timeout_hit_s = 1'b0;
        resp_data_s   = P_TIMEOUT_RDATA;
        if (cmd_master.ack) begin
            resp_data_s   = cmd_master.rdata;
        end else begin
            timeout_hit_s = (cnt_r == CNT_LAST);
        end
        cmd_done_s = cmd_master.ack | timeout_hit_s;
    end

    // Transaction sequencer; every output is set on entry to the state that owns it.
    always_ff @(posedge i_sysclk) begin
        if (i_srst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            skip_r      <= 1'b0;
            rdata_r     <= '0;
            sel_r       <= 1'b0;
            rd_wr_n_r   <= 1'b1;
            byte_addr_r <= '0;
            wdata_r     <= '0;
            ad_r        <= '0;
            oe_r        <= 1'b0;
            slave_ack_r <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            sel_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_mib_start) begin
                        rd_wr_n_r <= i_mib_rd_wr_n;
                        byte_addr_r[ADDR_HI_MSB:ADDR_HI_LSB] <= i_mib_ad[A1_ADDR_MSB:A1_ADDR_LSB];
                        state_r   <= ST_ADDR2;
                    end
                end
                ST_ADDR2: begin
                    byte_addr_r[ADDR_LO_MSB:ADDR_LO_LSB] <= i_mib_ad;
                    if (byte_addr_r[ADDR_MSN_MSB:ADDR_MSN_LSB] != P_MIB_MSN) begin
                        // A foreign write still has two data phases to let pass.
                        skip_r  <= ~rd_wr_n_r;
                        state_r <= ST_SKIP;
                    end else if (rd_wr_n_r) begin
                        sel_r   <= 1'b1;
                        state_r <= ST_CMD_REQ;
                    end else begin
                        state_r <= ST_WDATA_HI;
                    end
                end
                ST_WDATA_HI: begin
                    wdata_r[31:16] <= i_mib_ad;
                    state_r        <= ST_WDATA_LO;
                end
                ST_WDATA_LO: begin
                    wdata_r[15:0] <= i_mib_ad;
                    sel_r         <= 1'b1;
                    state_r       <= ST_CMD_REQ;
                end
                ST_CMD_REQ: begin
                    cnt_r   <= '0;
                    state_r <= ST_CMD_WAIT;
                end
                ST_CMD_WAIT: begin
                    if (cmd_done_s) begin
                        rdata_r   <= resp_data_s;
                        timeout_r <= timeout_r | timeout_hit_s;
                        if (rd_wr_n_r) begin
                            oe_r        <= 1'b1;
                            slave_ack_r <= 1'b1;
                            ad_r        <= data_half(resp_data_s, 1'b1);
                            state_r     <= ST_RD_HI;
                        end else begin
                            slave_ack_r <= 1'b1;
                            state_r     <= ST_WR_ACK;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_WR_ACK: begin
                    slave_ack_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                ST_RD_HI: begin
                    ad_r    <= data_half(rdata_r, 1'b0);
                    state_r <= ST_RD_LO;
                end
                ST_RD_LO: begin
                    oe_r        <= 1'b0;
                    slave_ack_r <= 1'b0;
                    ad_r        <= '0;
                    state_r     <= ST_IDLE;
                end
                ST_SKIP: begin
                    if (skip_r) begin
                        skip_r  <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    oe_r        <= 1'b0;
                    slave_ack_r <= 1'b0;
                    ad_r        <= '0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
